// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, source-index type, address helper.
package noc_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 3;
    localparam int FLIT_WIDTH = DATA_WIDTH + ADDR_WIDTH;
    localparam int NUM_IN     = 4;
    localparam int ID_WIDTH   = $clog2(NUM_IN);

    typedef logic [ID_WIDTH-1:0]   src_id_t;
    typedef logic [FLIT_WIDTH-1:0] flit_t;

    // Destination address lives in the top ADDR_WIDTH bits of a flit.
    function automatic logic [ADDR_WIDTH-1:0] flit_addr(input flit_t f);
        return f[FLIT_WIDTH-1 -: ADDR_WIDTH];
    endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Rotate-priority picker: first requester at or after ptr, wrapping.
module noc_rr_pick
    import noc_pkg::*;
#(
    parameter int N  = NUM_IN,
    parameter int IW = ID_WIDTH
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0] k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            // ptr < N, so one subtraction is enough for any N
            k = {1'b0, ptr} + (IW+1)'(i);
            if (k >= (IW+1)'(N)) begin
                k = k - (IW+1)'(N);
            end
            if (!any && req[k[IW-1:0]]) begin
                any             = 1'b1;
                idx             = k[IW-1:0];
                grant[k[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_link_arbiter.sv
// Round-robin arbiter sharing one NoC link among NumIn requesters,
// with a 2-entry output buffer for registered outputs at full rate.
module noc_link_arbiter
    import noc_pkg::*;
#(
    parameter int FlitWidth = FLIT_WIDTH,
    parameter int NumIn     = 4,
    parameter int IdWidth   = 2
) (
    input  logic                       i_sclk,
    input  logic                       i_reset,
    input  logic [NumIn*FlitWidth-1:0] i_req_data,
    input  logic [NumIn-1:0]           i_req_valid,
    output logic [NumIn-1:0]           o_req_ready,
    output logic [FlitWidth-1:0]       o_link_data,
    output logic                       o_link_valid,
    input  logic                       i_link_ready,
    output logic [IdWidth-1:0]         o_link_src,
    output logic                       o_busy
);

    logic [IdWidth-1:0]   ptr;
    logic [IdWidth-1:0]   win;
    logic [NumIn-1:0]     grant;
    logic                 any;
    logic [1:0]           count;
    logic [1:0]           count_next;
    logic [FlitWidth-1:0] win_data;
    logic [FlitWidth-1:0] tail_data;
    logic [IdWidth-1:0]   tail_src;
    logic                 push;
    logic                 pop;

    noc_rr_pick #(
        .N  (NumIn),
        .IW (IdWidth)
    ) u_pick (
        .req   (i_req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win),
        .any   (any)
    );

    assign win_data    = i_req_data[int'(win)*FlitWidth +: FlitWidth];
    assign push        = any && (count != 2'd2);
    assign pop         = o_link_valid && i_link_ready;
    assign o_req_ready = push ? grant : '0;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    // Head entry doubles as the output register; tail holds the spill.
    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            ptr          <= '0;
            count        <= '0;
            o_link_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_link_data  <= '0;
            o_link_src   <= '0;
            tail_data    <= '0;
            tail_src     <= '0;
        end else begin
            count        <= count_next;
            o_link_valid <= (count_next != 2'd0);
            o_busy       <= (count_next != 2'd0);
            if (push) begin
                ptr <= (win == IdWidth'(NumIn-1)) ? '0 : win + 1'b1;
            end
            case (count)
                2'd0: begin
                    if (push) begin
                        o_link_data <= win_data;
                        o_link_src  <= win;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        o_link_data <= win_data;
                        o_link_src  <= win;
                    end else if (push) begin
                        tail_data <= win_data;
                        tail_src  <= win;
                    end
                end
                default: begin
                    if (pop) begin
                        o_link_data <= tail_data;
                        o_link_src  <= tail_src;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Randomised bench for noc_link_arbiter against a queue-based model.
module tb_noc_link_arbiter;

    localparam int FW = 35;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*FW-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [FW-1:0]   link_data;
    logic            link_valid;
    logic            link_ready;
    logic [IW-1:0]   link_src;
    logic            busy;

    logic [3*FW-1:0] d3;
    logic [2:0]      v3;
    logic [2:0]      rdy3;
    logic [FW-1:0]   ld3;
    logic            lv3;
    logic [1:0]      ls3;
    logic            b3;

    always #5 clk = ~clk;

    noc_link_arbiter #(
        .FlitWidth (FW),
        .NumIn     (N),
        .IdWidth   (IW)
    ) dut (
        .i_sclk       (clk),
        .i_reset      (rst),
        .i_req_data   (req_data),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .o_link_data  (link_data),
        .o_link_valid (link_valid),
        .i_link_ready (link_ready),
        .o_link_src   (link_src),
        .o_busy       (busy)
    );

    noc_link_arbiter #(
        .FlitWidth (FW),
        .NumIn     (3),
        .IdWidth   (2)
    ) dut3 (
        .i_sclk       (clk),
        .i_reset      (rst),
        .i_req_data   (d3),
        .i_req_valid  (v3),
        .o_req_ready  (rdy3),
        .o_link_data  (ld3),
        .o_link_valid (lv3),
        .i_link_ready (1'b1),
        .o_link_src   (ls3),
        .o_busy       (b3)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: a plain queue of flits plus the rotating priority index.
    typedef struct {
        int            src;
        logic [FW-1:0] d;
    } ent_t;

    ent_t q[$];
    int   mptr;
    int   wait_cnt[N];
    bit   chk_en = 0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int w;
        logic [N-1:0] er;
        if (chk_en) begin
            w  = (q.size() < 2) ? pick(req_valid, mptr) : -1;
            er = '0;
            if (w >= 0) er[w] = 1'b1;
            check("ready", req_ready, er);
            check("onehot", $onehot0(req_ready), 1);
            check("valid", link_valid, q.size() > 0);
            check("busy", busy, q.size() > 0);
            if (q.size() > 0) begin
                check("data", link_data, q[0].d);
                check("src", link_src, q[0].src);
            end
            if (rst) begin
                q.delete();
                mptr = 0;
                for (int k = 0; k < N; k++) wait_cnt[k] = 0;
            end else begin
                if (q.size() > 0 && link_ready) void'(q.pop_front());
                if (w >= 0) begin
                    check("wait", wait_cnt[w] <= N - 1, 1);
                    wait_cnt[w] = 0;
                    for (int k = 0; k < N; k++) begin
                        if (k != w && req_valid[k]) wait_cnt[k]++;
                    end
                    q.push_back('{w, req_data[w*FW +: FW]});
                    mptr = (w + 1) % N;
                end
            end
        end
    end

    // Random driver: a requester keeps its flit until it is taken.
    bit           drv_en = 0;
    int           pval   = 0;
    int           prdy   = 100;
    int           seq    = 0;
    logic [N-1:0] xfer_q = '0;

    always @(negedge clk) xfer_q = req_valid & req_ready;

    always @(posedge clk) begin
        #3;
        if (drv_en) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] || xfer_q[k]) begin
                    req_valid[k] = ($urandom_range(99) < pval);
                    req_data[k*FW +: FW] =
                        {3'($urandom), 8'(k), 24'(seq)};
                    seq++;
                end
            end
            link_ready = ($urandom_range(99) < prdy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        req_data   = '0;
        req_valid  = '0;
        link_ready = 1'b1;
        d3         = '0;
        v3         = '0;
        tick();
        chk_en = 1;
        tick();
        rst = 1'b0;
        check("rst_valid", link_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", link_data, 0);
        check("rst_src", link_src, 0);

        // three requesters: pointer must wrap from 2 back to 0
        v3 = 3'b100;
        d3[2*FW +: FW] = 35'h5_0000_0003;
        #1 check("w3_rdy_a", rdy3, 3'b100);
        tick();
        v3 = 3'b101;
        d3[0 +: FW] = 35'h4_0000_0001;
        #1 check("w3_rdy_b", rdy3, 3'b001);
        check("w3_src_a", ls3, 2);
        tick();
        v3 = '0;
        check("w3_src_b", ls3, 0);
        check("w3_data_b", ld3, 35'h4_0000_0001);

        // single request from requester 2
        req_data[2*FW +: FW] = 35'h1_0000_00AA;
        req_valid = 4'b0100;
        #1 check("one_rdy", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check("one_valid", link_valid, 1);
        check("one_data", link_data, 35'h1_0000_00AA);
        check("one_src", link_src, 2);
        for (int k = 0; k < N; k++) req_data[k*FW +: FW] = 35'(k + 16);
        req_valid = 4'b1111;
        #1 check("ptr3_rdy", req_ready, 4'b1000);
        pval   = 100;
        prdy   = 100;
        drv_en = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_valid", link_valid, 1);
            check("rr_src", link_src, (3 + i) % 4);
        end

        // backpressure: two accepted, then frozen
        drv_en = 0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        link_ready = 1'b0;
        req_data[0 +: FW]  = 35'h0_1234_5678;
        req_data[FW +: FW] = 35'h2_0000_BBBB;
        req_valid = 4'b0011;
        #1 check("bp_rdy_a", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0010;
        #1 check("bp_rdy_b", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0001;
        req_data[0 +: FW] = 35'h7_CCCC_0000;
        #1 check("bp_full", req_ready, 4'b0000);
        tick();
        tick();
        check("bp_hold_d", link_data, 35'h0_1234_5678);
        check("bp_hold_s", link_src, 0);
        link_ready = 1'b1;
        #1 check("bp_nodep", req_ready, 4'b0000);
        tick();
        check("bp_out_b", link_data, 35'h2_0000_BBBB);
        check("bp_src_b", link_src, 1);
        #1 check("bp_ptr2", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        check("bp_out_c", link_data, 35'h7_CCCC_0000);
        check("bp_src_c", link_src, 0);
        tick();
        check("bp_empty", link_valid, 0);

        // reset while full
        rst = 1'b1;
        tick();
        rst = 1'b0;
        link_ready = 1'b0;
        req_data[0 +: FW] = 35'h0_0000_0A0A;
        req_valid = 4'b0001;
        tick();
        req_data[2*FW +: FW] = 35'h6_0000_0C0C;
        req_valid = 4'b0100;
        tick();
        req_data[FW +: FW] = 35'h3_1111_1111;
        req_valid = 4'b0110;
        #1 check("rm_busy", busy, 1);
        check("rm_rdy", req_ready, 4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_valid", link_valid, 0);
        check("rm_busy0", busy, 0);
        #1 check("rm_rdy1", req_ready, 4'b0010);
        link_ready = 1'b1;
        tick();
        req_valid = 4'b0100;
        check("rm_src", link_src, 1);
        check("rm_data", link_data, 35'h3_1111_1111);

        // random soak
        tick();
        pval   = 60;
        prdy   = 70;
        drv_en = 1;
        repeat (3000) tick();
        pval = 90;
        prdy = 30;
        repeat (2000) tick();
        pval = 0;
        prdy = 100;
        repeat (40) tick();
        check("end_valid", link_valid, 0);
        check("end_busy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
